// File: rtl/jk_reg_bank_v.sv
// WIDTH-bit bank of JK flip-flops with built-in synchronous up/down counter mode.
// Optional synchronous clear port 'sclr' is present when JK_SYNC_CLEAR_EN is defined.
module jk_reg_bank_v #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef JK_SYNC_CLEAR_EN
    input  logic             sclr,
`endif
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             tc
);

    typedef enum logic [1:0] {
        MODE_JK   = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    logic             sync_clr;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] q_next;
    logic             tc_next;
    logic             carry;

`ifdef JK_SYNC_CLEAR_EN
    assign sync_clr = sclr;
`else
    assign sync_clr = 1'b0;
`endif

    // Each bit flips when every lower bit is 1 (up) or 0 (down): a ripple toggle chain.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        toggle  = '0;
        q_next  = Q;
        tc_next = 1'b0;
        carry   = 1'b1;
        unique case (mode_e'(mode))
            MODE_JK: begin
                q_next = (J & ~Q) | (~K & Q);
            end
            MODE_UP: begin
                for (int i = 0; i < WIDTH; i++) begin
                    toggle[i] = carry;
                    carry     = carry & Q[i];
                end
                q_next  = Q ^ toggle;
                tc_next = &Q;
            end
            MODE_DOWN: begin
                for (int i = 0; i < WIDTH; i++) begin
                    toggle[i] = carry;
                    carry     = carry & ~Q[i];
                end
                q_next  = Q ^ toggle;
                tc_next = ~|Q;
            end
            MODE_HOLD: begin
                q_next = Q;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q  <= RST_VAL;
            tc <= 1'b0;
        end else if (sync_clr) begin
            Q  <= RST_VAL;
            tc <= 1'b0;
        end else if (en) begin
            Q  <= q_next;
            tc <= tc_next;
        end else begin
            tc <= 1'b0;
        end
    end

    // Derived from Q rather than registered, so Q and Qbar can never disagree.
    assign Qbar = ~Q;

endmodule

// File: tb/tb_jk_reg_bank_v.sv
// Directed self-checking bench for jk_reg_bank_v (WIDTH=4, RST_VAL=0 and RST_VAL=4'hA).
// Define JK_SYNC_CLEAR_EN for both files to exercise the sclr port.
module tb_jk_reg_bank_v;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_a = 1'b1;
    logic       en = 1'b0;
    logic       sclr = 1'b0;
    logic [1:0] mode = 2'b11;
    logic [3:0] J = '0;
    logic [3:0] K = '0;
    logic [3:0] q, qbar, q_a, qbar_a;
    logic       tc, tc_a;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    jk_reg_bank_v #(.WIDTH(4), .RST_VAL(4'h0)) dut (
        .clk(clk), .rst(rst), .en(en),
`ifdef JK_SYNC_CLEAR_EN
        .sclr(sclr),
`endif
        .mode(mode), .J(J), .K(K), .Q(q), .Qbar(qbar), .tc(tc)
    );

    jk_reg_bank_v #(.WIDTH(4), .RST_VAL(4'hA)) dut_a (
        .clk(clk), .rst(rst_a), .en(en),
`ifdef JK_SYNC_CLEAR_EN
        .sclr(1'b0),
`endif
        .mode(mode), .J(J), .K(K), .Q(q_a), .Qbar(qbar_a), .tc(tc_a)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Async reset with no clock edge yet.
        #2;
        check("rst_q", q, 4'h0);
        check("rst_qbar", qbar, 4'hF);
        check("rst_tc", tc, 1'b0);
        rst = 1'b0;

        // JK mode
        en = 1'b1; mode = 2'b00; J = 4'b1010; K = 4'b0101;
        step();
        check("jk_set", q, 4'b1010);
        check("jk_set_qbar", qbar, 4'b0101);
        J = 4'b1111; K = 4'b1111;
        step();
        check("jk_toggle", q, 4'b0101);
        J = 4'b0000; K = 4'b0000;
        step();
        check("jk_hold", q, 4'b0101);
        J = 4'b0010; K = 4'b0101;
        step();
        check("jk_mixed", q, 4'b0010);
        check("jk_tc", tc, 1'b0);
        J = 4'b0000; K = 4'b1111;
        step();
        check("jk_clear", q, 4'b0000);

        // Up count 0..15,0 with an en=0 gap mid-count
        mode = 2'b01;
        for (int i = 1; i <= 16; i++) begin
            step();
            check($sformatf("up_q_%0d", i), q, i % 16);
            check($sformatf("up_tc_%0d", i), tc, (i == 16));
            if (i == 8) begin
                en = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    step();
                    check("en0_hold_q", q, 4'h8);
                    check("en0_tc", tc, 1'b0);
                end
                en = 1'b1;
            end
        end

        // Down wrap, then switch to up
        mode = 2'b10;
        step();
        check("dn_wrap_q", q, 4'hF);
        check("dn_wrap_tc", tc, 1'b1);
        step();
        check("dn_q", q, 4'hE);
        check("dn_tc", tc, 1'b0);
        mode = 2'b01;
        step();
        check("sw_up_q", q, 4'hF);
        check("sw_up_tc", tc, 1'b0);
        step();
        check("sw_wrap_q", q, 4'h0);
        check("sw_wrap_tc", tc, 1'b1);
        mode = 2'b11; J = 4'hF; K = 4'h0;
        step();
        check("hold_q", q, 4'h0);
        check("hold_tc", tc, 1'b0);

        // Async reset kills a tc pulse in progress
        mode = 2'b10;
        step();
        check("pre_rst_tc", tc, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_q", q, 4'h0);
        check("mid_rst_tc", tc, 1'b0);
        rst = 1'b0;

        // RST_VAL=4'hA instance: reset mid-count, resume from RST_VAL
        check("a_rst_q", q_a, 4'hA);
        check("a_rst_qbar", qbar_a, 4'h5);
        rst_a = 1'b0; mode = 2'b01;
        step();
        check("a_up1", q_a, 4'hB);
        step();
        check("a_up2", q_a, 4'hC);
        #2;
        rst_a = 1'b1;
        #1;
        check("a_mid_rst_q", q_a, 4'hA);
        check("a_mid_rst_tc", tc_a, 1'b0);
        rst_a = 1'b0;
        step();
        check("a_resume", q_a, 4'hB);

`ifdef JK_SYNC_CLEAR_EN
        // Synchronous clear overrides en=0 and count mode
        rst = 1'b1; #1; rst = 1'b0;
        mode = 2'b01; en = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("sclr_pre", q, 4'h7);
        sclr = 1'b1; en = 1'b0;
        step();
        check("sclr_q", q, 4'h0);
        check("sclr_tc", tc, 1'b0);
        sclr = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
